// File: rtl/polyvecl_pointwise_montgomery_stream.sv
// Loads poly a, then streams L polys of v through one Montgomery multiplier (pointwise or accumulate).
// Latency 3 cycles input->output; an output stall freezes the whole pipeline and deasserts in_ready.
module polyvecl_pointwise_montgomery_stream #(
    parameter int          L    = 5,
    parameter int          N    = 256,
    parameter logic [31:0] Q    = 32'd8380417,
    parameter logic [31:0] QINV = 32'd58728449
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        acc_mode,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);
    localparam int JW     = $clog2(N);
    localparam int IW     = (L > 1) ? $clog2(L) : 1;
    localparam bit ACC_OK = (L > 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [JW-1:0]   r_j;
    logic [IW-1:0]   r_i;
    logic            r_acc;
    logic [31:0]     r_a_mem   [N];
    logic [31:0]     r_acc_mem [N];

    logic            r_s1_vld, r_s2_vld;
    logic [63:0]     r_s1_p, r_s2_p;
    logic [31:0]     r_s2_t;
    logic [JW-1:0]   r_s1_j, r_s2_j;
    logic [IW-1:0]   r_s1_i, r_s2_i;

    logic            w_pipe_en, w_load, w_push, w_j_last, w_i_last;
    logic [31:0]     w_a, w_t, w_r, w_acc_rd, w_sum;
    logic [63:0]     w_p, w_tq, w_diff;
    logic            w_accum, w_s2_last_poly, w_emit;

    assign w_pipe_en = !(out_valid && !out_ready);
    assign w_load    = (r_state == S_LOAD_A) && in_valid;
    assign w_push    = (r_state == S_STREAM) && in_valid && w_pipe_en;
    assign w_j_last  = (r_j == JW'(N - 1));
    assign w_i_last  = (r_i == IW'(L - 1));

    assign in_ready  = (r_state == S_LOAD_A) || ((r_state == S_STREAM) && w_pipe_en);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_A;
            S_LOAD_A: if (w_load && w_j_last) w_next = S_STREAM;
            S_STREAM: if (w_push && w_j_last && w_i_last) w_next = S_DRAIN;
            S_DRAIN:  if (!r_s1_vld && !r_s2_vld && !out_valid) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Mode is latched only when a start is accepted, so later acc_mode wiggles are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j   <= '0;
            r_i   <= '0;
            r_acc <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_j   <= '0;
            r_i   <= '0;
            r_acc <= acc_mode;
        end else if (w_load || w_push) begin
            if (w_j_last) begin
                r_j <= '0;
                if (w_push) r_i <= w_i_last ? '0 : r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) r_a_mem[r_j] <= in_data;
    end

    assign w_a    = r_a_mem[r_j];
    assign w_p    = {{32{w_a[31]}}, w_a} * {{32{in_data[31]}}, in_data};
    assign w_t    = r_s1_p[31:0] * QINV;
    assign w_tq   = {{32{r_s2_t[31]}}, r_s2_t} * {32'd0, Q};
    // Low halves of p and t*Q cancel exactly, so the shift is just the upper word.
    assign w_diff = r_s2_p - w_tq;
    assign w_r    = 32'(w_diff >> 32);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else if (w_pipe_en) begin
            r_s1_vld <= w_push;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pipe_en) begin
            r_s1_p <= w_p;
            r_s1_j <= r_j;
            r_s1_i <= r_i;
            r_s2_p <= r_s1_p;
            r_s2_t <= w_t;
            r_s2_j <= r_s1_j;
            r_s2_i <= r_s1_i;
        end
    end

    assign w_accum        = r_acc && ACC_OK;
    assign w_s2_last_poly = (r_s2_i == IW'(L - 1));
    assign w_acc_rd       = r_acc_mem[r_s2_j];
    assign w_emit         = r_s2_vld && (!w_accum || w_s2_last_poly);
    assign w_sum          = w_accum ? (w_acc_rd + w_r) : w_r;

    // Same j comes back only N cycles later, so the async read never sees a pending write.
    always_ff @(posedge clk) begin
        if (w_pipe_en && r_s2_vld && w_accum && !w_s2_last_poly)
            r_acc_mem[r_s2_j] <= (r_s2_i == '0) ? w_r : (w_acc_rd + w_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (w_pipe_en) begin
            out_valid <= w_emit;
            out_last  <= w_emit && w_s2_last_poly && (r_s2_j == JW'(N - 1));
            if (w_emit) out_data <= w_sum;
        end
    end
endmodule
